// File: rtl/rf_write_buffer.sv
// rf_write_buffer: small circular FIFO that queues register-file writes
// when the regfile write port is busy, drains them in acceptance order at
// one write per cycle, and forwards pending data to the two read ports.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   in_valid/in_ready           write request handshake
//   in_addr, in_data            request register index and value
//   rf_hold                     regfile write port unavailable this cycle
//   rf_wen/rf_waddr/rf_wdata    regfile write port (head entry)
//   raddr1/raddr2               read addresses also seen by the regfile
//   rf_rdata1/rf_rdata2         raw regfile read data
//   rdata1/rdata2               read data with pending-write bypass
//   count, full, empty          occupancy status
module rf_write_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_addr,
  input  logic [31:0] in_data,
  input  logic        rf_hold,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [3:0]  count,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] occ;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic push;
  logic pop;

  // Occupancy as seen by outputs; forced empty while reset is held so the
  // outputs show reset values before the first clearing edge.
  assign occ      = resetn ? count_q : '0;
  assign count    = occ;
  assign full     = (occ == DEPTH_C);
  assign empty    = (occ == '0);
  assign in_ready = !full;

  // Address 0 completes the handshake but is never stored.
  assign push = in_valid && in_ready && (in_addr != AW'(0));

  assign rf_wen = !empty && !rf_hold;
  assign pop    = rf_wen;

  // Head entry drives the write port; zeros when nothing is pending.
  assign rf_waddr = empty ? '0 : addr_q[head_q];
  assign rf_wdata = empty ? '0 : data_q[head_q];

  // Next-state for pointers and occupancy; power-of-two depth wraps naturally.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are not cleared, validity comes from count.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  // Bypass: walk oldest to youngest so the youngest match wins. The entry
  // being pushed this cycle is not yet in storage and is therefore ignored.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx    = head_q;
    rdata1 = rf_rdata1;
    rdata2 = rf_rdata2;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < occ) begin
        if ((raddr1 != AW'(0)) && (addr_q[idx] == raddr1)) begin
          rdata1 = data_q[idx];
        end
        if ((raddr2 != AW'(0)) && (addr_q[idx] == raddr2)) begin
          rdata2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_write_buffer.sv
// Directed bench for rf_write_buffer (DEPTH=4).
module tb_rf_write_buffer;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        rf_hold;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  int n_vec;
  int n_err;

  rf_write_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .rf_hold   (rf_hold),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rdata1    (rdata1),
    .rdata2    (rdata2),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    rf_hold   = 1'b0;
    raddr1    = '0;
    raddr2    = '0;
    rf_rdata1 = 32'hCAFE0001;
    rf_rdata2 = 32'hCAFE0002;

    // Reset values
    step();
    step();
    raddr1 = 5'd3;
    settle();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_rf_wen",   32'(rf_wen),   32'd0);
    chk("rst_waddr",    32'(rf_waddr), 32'd0);
    chk("rst_wdata",    rf_wdata,      32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_count",    32'(count),    32'd0);
    chk("rst_rdata1",   rdata1,        32'hCAFE0001);
    resetn = 1'b1;
    step();

    // Single push, no hold: no pass-through, written next cycle, then empty
    in_valid = 1'b1; in_addr = 5'd3; in_data = 32'h11111111;
    settle();
    chk("s1_ready",      32'(in_ready), 32'd1);
    chk("s1_no_passthru", 32'(rf_wen),  32'd0);
    chk("s1_no_bypass_inflight", rdata1, 32'hCAFE0001);
    step();
    in_valid = 1'b0;
    settle();
    chk("s1_count", 32'(count),    32'd1);
    chk("s1_wen",   32'(rf_wen),   32'd1);
    chk("s1_waddr", 32'(rf_waddr), 32'd3);
    chk("s1_wdata", rf_wdata,      32'h11111111);
    chk("s1_bypass_head", rdata1,  32'h11111111);
    step();
    chk("s1_empty", 32'(empty),  32'd1);
    chk("s1_wen0",  32'(rf_wen), 32'd0);

    // Fill under hold, fifth request stalls, drain in order
    rf_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_addr = 5'(i); in_data = 32'hA0 + 32'(i);
      step();
    end
    in_addr = 5'd7; in_data = 32'hA7;
    settle();
    chk("s2_full",  32'(full),     32'd1);
    chk("s2_ready", 32'(in_ready), 32'd0);
    chk("s2_count", 32'(count),    32'd4);
    chk("s2_hold_wen", 32'(rf_wen), 32'd0);
    step();
    chk("s2_stall_count", 32'(count), 32'd4);
    chk("s2_stable_waddr", 32'(rf_waddr), 32'd1);
    chk("s2_stable_wdata", rf_wdata, 32'hA1);
    in_valid = 1'b0;
    rf_hold  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk($sformatf("s2_wen_%0d", k),   32'(rf_wen),   32'd1);
      chk($sformatf("s2_waddr_%0d", k), 32'(rf_waddr), 32'(k));
      chk($sformatf("s2_wdata_%0d", k), rf_wdata,      32'hA0 + 32'(k));
      step();
    end
    chk("s2_ready_after", 32'(in_ready), 32'd1);
    chk("s2_empty_after", 32'(empty),    32'd1);

    // Bypass: youngest match wins; unmatched passes through
    rf_hold = 1'b1;
    raddr1 = 5'd5; rf_rdata1 = 32'h0;
    raddr2 = 5'd6; rf_rdata2 = 32'h1234;
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'hAAAA0000;
    step();
    in_data = 32'hBBBB0000;
    settle();
    chk("s3_older_only", rdata1, 32'hAAAA0000);
    step();
    in_valid = 1'b0;
    settle();
    chk("s3_rdata1_young", rdata1, 32'hBBBB0000);
    chk("s3_rdata2_miss",  rdata2, 32'h00001234);
    raddr2 = 5'd5;
    settle();
    chk("s3_rdata2_young", rdata2, 32'hBBBB0000);
    rf_hold = 1'b0;
    step();
    chk("s3_after_pop1", rdata1, 32'hBBBB0000);
    step();
    rf_rdata1 = 32'h55;
    settle();
    chk("s3_drained", rdata1, 32'h55);
    chk("s3_empty",   32'(empty), 32'd1);
    raddr2 = 5'd0;

    // Address 0 accepted and dropped; raddr 0 never bypasses
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFFFFFF;
    settle();
    chk("s4_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    raddr1 = 5'd0; rf_rdata1 = 32'h77;
    settle();
    chk("s4_count", 32'(count),  32'd0);
    chk("s4_wen",   32'(rf_wen), 32'd0);
    chk("s4_rdata1", rdata1,     32'h77);
    step();
    chk("s4_wen_later", 32'(rf_wen), 32'd0);

    // Steady push+pop with two pending: count holds, pointers wrap, order kept
    rf_hold = 1'b1;
    in_valid = 1'b1; in_addr = 5'd10; in_data = 32'hD00;
    step();
    in_addr = 5'd11; in_data = 32'hD01;
    step();
    rf_hold = 1'b0;
    for (int j = 0; j < 10; j++) begin
      in_valid = 1'b1; in_addr = 5'(12 + j); in_data = 32'hD02 + 32'(j);
      settle();
      chk($sformatf("s5_count_%0d", j), 32'(count),    32'd2);
      chk($sformatf("s5_waddr_%0d", j), 32'(rf_waddr), 32'(10 + j));
      chk($sformatf("s5_wdata_%0d", j), rf_wdata,      32'hD00 + 32'(j));
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("s5_tail_waddr0", 32'(rf_waddr), 32'd20);
    step();
    chk("s5_tail_waddr1", 32'(rf_waddr), 32'd21);
    chk("s5_tail_wdata1", rf_wdata,      32'hD0B);
    step();
    chk("s5_empty", 32'(empty), 32'd1);

    // Reset with three pending entries drops them all
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 5'(13 + i); in_data = 32'hE0 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    settle();
    chk("s6_count_pre", 32'(count), 32'd3);
    resetn  = 1'b0;
    rf_hold = 1'b0;
    settle();
    chk("s6_wen_in_rst", 32'(rf_wen), 32'd0);
    step();
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("s6_count_%0d", c), 32'(count),  32'd0);
      chk($sformatf("s6_wen_%0d", c),   32'(rf_wen), 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
